// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Write buffer between the memory pipeline stage and a
//                byte-addressable data memory. Stores are queued in a small
//                FIFO and drained one per cycle whenever the memory port is
//                not taken by a load. Loads have priority on the port. A load
//                whose byte range overlaps any pending store is held off
//                while the buffer drains. Misaligned or illegal requests are
//                consumed with misalign=1 and never reach memory.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   system clock, rising edge
//    rst          in   synchronous active-high reset
//    req_valid    in   memory-stage request present
//    req_we       in   1 = store, 0 = load
//    req_addr     in   [31:0] byte address
//    req_wdata    in   [31:0] store data (low bytes for SB/SH)
//    req_funct3   in   [2:0]  000 B, 001 H, 010 W, 100 BU, 101 HU
//    req_ready    out  request consumed this cycle
//    load_data    out  [31:0] load result (valid when a load is accepted)
//    misalign     out  request rejected (misaligned / illegal funct3)
//    empty        out  no pending stores
//    mem_wr_en    out  memory write strobe (drain of head entry)
//    mem_rd_en    out  memory read strobe (accepted load)
//    mem_addr     out  [31:0] memory byte address
//    mem_wr_data  out  [31:0] memory write data
//    mem_funct3   out  [2:0]  memory access size/sign
//    mem_rd_data  in   [31:0] combinational memory read data
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        req_ready,
    output logic [31:0] load_data,
    output logic        misalign,
    output logic        empty,
    output logic        mem_wr_en,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rd_data
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    // Access size minus one, from the low two funct3 bits (B=0, H=1, W=3).
    function automatic logic [1:0] f_size_m1(input logic [1:0] size_code);
        return {size_code[1], size_code[1] | size_code[0]};
    endfunction

    // ------------------------------------------------------------------
    // Storage and FIFO state
    // ------------------------------------------------------------------
    logic [31:0]        r_addr [DEPTH];
    logic [31:0]        r_data [DEPTH];
    logic [2:0]         r_f3   [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    // ------------------------------------------------------------------
    // Request legality
    // ------------------------------------------------------------------
    logic        w_f3_ok;
    logic        w_align_ok;
    logic        w_legal;
    logic [31:0] w_req_last;

    always_comb begin
        w_f3_ok = 1'b0;
        if (req_we) begin
            w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010);
        end else begin
            w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                      (req_funct3 == 3'b010) || (req_funct3 == 3'b100) ||
                      (req_funct3 == 3'b101);
        end
    end

    always_comb begin
        w_align_ok = 1'b1;
        case (req_funct3[1:0])
            2'b01:   w_align_ok = (req_addr[0] == 1'b0);
            2'b10:   w_align_ok = (req_addr[1:0] == 2'b00);
            default: w_align_ok = 1'b1;
        endcase
    end

    assign w_legal    = w_f3_ok & w_align_ok;
    // Aligned ranges never cross a 2^32 boundary, so a plain add is exact.
    assign w_req_last = req_addr + {30'd0, f_size_m1(req_funct3[1:0])};

    // ------------------------------------------------------------------
    // Per-slot overlap compare. A slot is live when its distance from the
    // head (modulo DEPTH) is below the occupancy count.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0] w_hit;
    logic             w_overlap;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [c_PTR_W-1:0] w_off;
        logic [31:0]        w_ent_last;

        assign w_off      = c_PTR_W'(gi) - r_head;
        assign w_ent_last = r_addr[gi] + {30'd0, f_size_m1(r_f3[gi][1:0])};
        assign w_hit[gi]  = (c_CNT_W'(w_off) < r_count) &&
                            (req_addr <= w_ent_last) &&
                            (r_addr[gi] <= w_req_last);
    end

    assign w_overlap = |w_hit;

    // ------------------------------------------------------------------
    // Port arbitration. Reset masks every request and every drain so that
    // pending stores are discarded without touching memory.
    // ------------------------------------------------------------------
    logic w_active;
    logic w_reject;
    logic w_load_acc;
    logic w_store_acc;
    logic w_full;
    logic w_drain;

    assign w_active    = req_valid & ~rst;
    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign w_reject    = w_active & ~w_legal;
    assign w_load_acc  = w_active & ~req_we & w_legal & ~w_overlap;
    // A full buffer refuses the store even when the head drains this cycle.
    assign w_store_acc = w_active & req_we & w_legal & ~w_full;
    assign w_drain     = ~rst & (r_count != '0) & ~w_load_acc;

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store_acc) begin
                r_addr[r_tail] <= req_addr;
                r_data[r_tail] <= req_wdata;
                r_f3[r_tail]   <= req_funct3;
                r_tail         <= r_tail + c_PTR_W'(1);
            end
            if (w_drain) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            case ({w_store_acc, w_drain})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_ready   = w_reject | w_load_acc | w_store_acc;
        misalign    = w_reject;
        load_data   = 32'd0;
        mem_rd_en   = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 32'd0;
        mem_wr_data = 32'd0;
        mem_funct3  = 3'd0;
        if (w_load_acc) begin
            mem_rd_en  = 1'b1;
            mem_addr   = req_addr;
            mem_funct3 = req_funct3;
            load_data  = mem_rd_data;
        end else if (w_drain) begin
            mem_wr_en   = 1'b1;
            mem_addr    = r_addr[r_head];
            mem_wr_data = r_data[r_head];
            mem_funct3  = r_f3[r_head];
        end
    end

    // Reset already discards every pending entry, so report empty at once.
    assign empty = rst | (r_count == '0);

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Self-checking bench for store_buffer. A byte memory model
//                sits on the memory port; a reference model (queue of
//                pending stores plus a committed-memory image) predicts
//                every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready;
    logic [31:0] load_data;
    logic        misalign;
    logic        empty;
    logic        mem_wr_en;
    logic        mem_rd_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd_data;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_funct3  (req_funct3),
        .req_ready   (req_ready),
        .load_data   (load_data),
        .misalign    (misalign),
        .empty       (empty),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_funct3  (mem_funct3),
        .mem_rd_data (mem_rd_data)
    );

    // ------------------------------------------------------------------
    // Physical memory attached to the port (4 KiB, little-endian)
    // ------------------------------------------------------------------
    logic [7:0]  mem [0:4095];
    logic        init_req;
    int          n_wr_10 = 0;
    logic [11:0] r_idx;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (mem_wr_en) begin
            mem[mem_addr[11:0]] <= mem_wr_data[7:0];
            if (mem_funct3[1:0] != 2'b00)
                mem[mem_addr[11:0] + 12'd1] <= mem_wr_data[15:8];
            if (mem_funct3[1:0] == 2'b10) begin
                mem[mem_addr[11:0] + 12'd2] <= mem_wr_data[23:16];
                mem[mem_addr[11:0] + 12'd3] <= mem_wr_data[31:24];
            end
            if (mem_addr == 32'h10) n_wr_10 <= n_wr_10 + 1;
        end
    end

    always_comb begin
        r_idx       = mem_addr[11:0];
        mem_rd_data = 32'd0;
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{mem[r_idx][7]}}, mem[r_idx]};
            3'b001:  mem_rd_data = {{16{mem[r_idx + 12'd1][7]}}, mem[r_idx + 12'd1], mem[r_idx]};
            3'b010:  mem_rd_data = {mem[r_idx + 12'd3], mem[r_idx + 12'd2],
                                    mem[r_idx + 12'd1], mem[r_idx]};
            3'b100:  mem_rd_data = {24'd0, mem[r_idx]};
            3'b101:  mem_rd_data = {16'd0, mem[r_idx + 12'd1], mem[r_idx]};
            default: mem_rd_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } st_t;

    st_t        q[$];
    logic [7:0] ref_mem [0:4095];
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 1;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] f3);
        int          sz;
        logic [31:0] v;
        sz = size_of(f3);
        v  = 0;
        for (int k = 0; k < sz; k++)
            v = v | (32'(ref_mem[(a + 32'(k)) & 32'hFFF]) << (8 * k));
        if (!f3[2] && sz < 4 && v[8 * sz - 1])
            v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        return v;
    endfunction

    task automatic ref_commit(input st_t s);
        for (int k = 0; k < size_of(s.f3); k++)
            ref_mem[(s.addr + 32'(k)) & 32'hFFF] = 8'(s.data >> (8 * k));
    endtask

    // One request cycle: drive, predict, compare, advance model.
    task automatic do_cycle(input logic v, input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] f3,
                            output logic rdy, output logic [31:0] ld);
        int   sz;
        logic legal, f3ok, ovl, e_ld, e_st, e_dr, e_rdy;
        rst = 1'b0; req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_funct3 = f3;
        @(negedge clk);
        sz    = size_of(f3);
        f3ok  = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        legal = f3ok && ((a % 32'(sz)) == 0);
        ovl   = 1'b0;
        foreach (q[i])
            if (a <= q[i].addr + 32'(size_of(q[i].f3) - 1) && q[i].addr <= a + 32'(sz - 1))
                ovl = 1'b1;
        e_ld  = v && !we && legal && !ovl;
        e_st  = v && we && legal && (q.size() < DEPTH);
        e_dr  = (q.size() > 0) && !e_ld;
        e_rdy = v && (!legal || e_ld || e_st);
        check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
        check_eq("misalign",  32'(misalign),  32'(v && !legal));
        check_eq("load_data", load_data, e_ld ? ref_read(a, f3) : 32'd0);
        check_eq("mem_rd_en", 32'(mem_rd_en), 32'(e_ld));
        check_eq("mem_wr_en", 32'(mem_wr_en), 32'(e_dr));
        check_eq("empty",     32'(empty),     32'(q.size() == 0));
        if (e_ld) begin
            check_eq("rd_addr", mem_addr, a);
            check_eq("rd_f3",   32'(mem_funct3), 32'(f3));
        end
        if (e_dr) begin
            check_eq("wr_addr", mem_addr, q[0].addr);
            check_eq("wr_data", mem_wr_data, q[0].data);
            check_eq("wr_f3",   32'(mem_funct3), 32'(q[0].f3));
        end
        rdy = req_ready;
        ld  = load_data;
        if (e_dr) begin
            ref_commit(q[0]);
            void'(q.pop_front());
        end
        if (e_st) q.push_back('{addr: a, data: d, f3: f3});
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle(input logic v, input logic we);
        rst = 1'b1; req_valid = v; req_we = we; req_addr = 32'h0; req_wdata = 32'h1234; req_funct3 = 3'b010;
        @(negedge clk);
        check_eq("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check_eq("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_misal", 32'(misalign),  32'd0);
        check_eq("rst_ld",    load_data,      32'd0);
        check_eq("rst_empty", 32'(empty),     32'd1);
        q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic        r;
        logic [31:0] l;
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, r, l);
    endtask

    // Retry a load until accepted; returns attempts used (0 = never accepted).
    task automatic load_retry(input logic [31:0] a, input logic [2:0] f3,
                              output int tries, output logic [31:0] ld);
        logic r;
        tries = 0;
        for (int i = 1; i <= 2 * DEPTH + 2; i++) begin
            do_cycle(1'b1, 1'b0, a, 32'h0, f3, r, ld);
            if (r) begin
                tries = i;
                break;
            end
        end
        check_eq("load_not_stuck", 32'(tries != 0), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic        r;
        logic [31:0] l;
        int          t;
        int          w0;

        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        rst = 1'b1; init_req = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 0; req_wdata = 0; req_funct3 = 0;
        @(posedge clk);
        #1;
        init_req = 1'b0;
        rst_cycle(1'b1, 1'b1);
        rst_cycle(1'b0, 1'b0);

        // Store followed directly by an overlapping load.
        do_cycle(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, r, l);
        load_retry(32'h100, 3'b010, t, l);
        check_eq("haz_tries", 32'(t), 32'd2);
        check_eq("haz_data",  l, 32'hDEADBEEF);

        // Byte overlap inside a word, and a neighbouring non-overlapping byte.
        do_cycle(1'b1, 1'b1, 32'h203, 32'h000000AA, 3'b000, r, l);
        load_retry(32'h200, 3'b010, t, l);
        check_eq("byte_ovl_tries", 32'(t), 32'd2);
        check_eq("byte_ovl_b3",    32'(l[31:24]), 32'hAA);
        do_cycle(1'b1, 1'b1, 32'h203, 32'h00000055, 3'b000, r, l);
        do_cycle(1'b1, 1'b0, 32'h204, 32'h0, 3'b000, r, l);
        check_eq("byte_noovl_rdy", 32'(r), 32'd1);
        idle(2);

        // Misaligned and illegal requests.
        do_cycle(1'b1, 1'b0, 32'h102, 32'h0, 3'b010, r, l);
        do_cycle(1'b1, 1'b1, 32'h101, 32'h5555, 3'b001, r, l);
        do_cycle(1'b1, 1'b0, 32'h100, 32'h0, 3'b011, r, l);
        do_cycle(1'b1, 1'b1, 32'h100, 32'h0, 3'b100, r, l);
        do_cycle(1'b1, 1'b0, 32'h0FE, 32'h0, 3'b101, r, l);
        check_eq("hu_odd_ok", 32'(r), 32'd1);

        // Stores interleaved with loads that hold the port.
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 3'b010, r, l);
            do_cycle(1'b1, 1'b0, 32'h800, 32'h0, 3'b010, r, l);
        end
        idle(DEPTH + 1);

        // Program-order drain of two stores to one word.
        w0 = n_wr_10;
        do_cycle(1'b1, 1'b1, 32'h10, 32'd1, 3'b010, r, l);
        do_cycle(1'b1, 1'b1, 32'h10, 32'd2, 3'b010, r, l);
        idle(DEPTH + 1);
        check_eq("order_nwr",  32'(n_wr_10 - w0), 32'd2);
        check_eq("order_word", {mem[19], mem[18], mem[17], mem[16]}, 32'd2);

        // Reset with stores pending, then read those addresses back.
        do_cycle(1'b1, 1'b1, 32'h300, 32'd11, 3'b010, r, l);
        do_cycle(1'b1, 1'b1, 32'h304, 32'd22, 3'b010, r, l);
        do_cycle(1'b1, 1'b1, 32'h308, 32'd33, 3'b010, r, l);
        rst_cycle(1'b1, 1'b1);
        rst_cycle(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) load_retry(32'h300 + 32'(4 * i), 3'b010, t, l);
        check_eq("rst_discard", l, {pat(32'h30B), pat(32'h30A), pat(32'h309), pat(32'h308)});

        // Randomized traffic over a small window to provoke hazards.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst_cycle(1'($urandom), 1'($urandom));
            end else begin
                do_cycle(($urandom_range(0, 9) < 8), 1'($urandom),
                         32'($urandom_range(0, 63)), $urandom, 3'($urandom), r, l);
            end
        end
        idle(DEPTH + 1);

        // Memory image must match the model's committed image.
        for (int a = 0; a < 1024; a += 4)
            check_eq("mem_image", {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]},
                     {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
